// File: rtl/capp_pkg.sv
// Shared constants and helpers for the associative-processor search datapath.
// Each searched bit is broadcast as a pair of mismatch lines.
package capp_pkg;

  localparam int WORDS = 100;
  localparam int WIDTH = 32;

  // Offset within a bit pair: line that trips cells storing 0 / storing 1.
  localparam int MM_ZERO = 0;
  localparam int MM_ONE  = 1;

  typedef logic [WIDTH-1:0] word_t;

  function automatic int mm_idx(input int bit_pos, input int offset);
    return 2 * bit_pos + offset;
  endfunction

endpackage

// File: rtl/cam_word.sv
// One associative word: storage, match NOR, masked write into a matching
// word, direct load, and match-gated read data.
module cam_word #(
  parameter int WIDTH = capp_pkg::WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] mismatch_lines,
  input  logic [2*WIDTH-1:0] write_lines,
  input  logic               load_en,
  input  logic [WIDTH-1:0]   load_data,
  output logic               match,
  output logic [WIDTH-1:0]   read_data
);
  import capp_pkg::*;

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] bit_mismatch;

  always_comb begin
    bit_mismatch = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_mismatch[i] = word_q[i] ? mismatch_lines[mm_idx(i, MM_ONE)]
                                  : mismatch_lines[mm_idx(i, MM_ZERO)];
    end
  end

  assign match     = ~|bit_mismatch;
  assign read_data = match ? word_q : '0;

  // Write uses the match from before the edge; conflicting set+clear leaves
  // the bit alone, and a direct load wins over any write.
  always_comb begin
    word_d = word_q;
    if (match) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({write_lines[mm_idx(i, MM_ONE)], write_lines[mm_idx(i, MM_ZERO)]})
          2'b10:   word_d[i] = 1'b1;
          2'b01:   word_d[i] = 1'b0;
          default: word_d[i] = word_q[i];
        endcase
      end
    end
    if (load_en) begin
      word_d = load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/cells.sv
// Array of associative words with load-address decode and a wired-OR read
// across all matching words.
module cells #(
  parameter int WORDS = capp_pkg::WORDS,
  parameter int WIDTH = capp_pkg::WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] mismatch_lines,
  input  logic [2*WIDTH-1:0] write_lines,
  input  logic               load_en,
  input  logic [6:0]         load_addr,
  input  logic [WIDTH-1:0]   load_data,
  output logic [WORDS-1:0]   match_lines,
  output logic [WIDTH-1:0]   read_lines
);

  logic [WIDTH-1:0] word_read [WORDS];

  // Addresses at or above WORDS decode to no word and are dropped.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic word_load;
    assign word_load = load_en && (load_addr == 7'(w));

    cam_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .CLK           (CLK),
      .RST           (RST),
      .mismatch_lines(mismatch_lines),
      .write_lines   (write_lines),
      .load_en       (word_load),
      .load_data     (load_data),
      .match         (match_lines[w]),
      .read_data     (word_read[w])
    );
  end

  always_comb begin
    read_lines = '0;
    for (int w = 0; w < WORDS; w++) begin
      read_lines = read_lines | word_read[w];
    end
  end

endmodule

// File: rtl/compare.sv
// Comparand/mask broadcast stage: registers the bit-pair mismatch pattern
// on a search request and holds it otherwise.
module compare #(
  parameter int WIDTH = capp_pkg::WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   comparand,
  input  logic [WIDTH-1:0]   mask,
  input  logic               perform_search,
  output logic [2*WIDTH-1:0] mismatch_lines
);
  import capp_pkg::*;

  logic [2*WIDTH-1:0] mismatch_d;
  logic [2*WIDTH-1:0] mismatch_q;

  always_comb begin
    mismatch_d = mismatch_q;
    if (perform_search) begin
      for (int i = 0; i < WIDTH; i++) begin
        mismatch_d[mm_idx(i, MM_ZERO)] = mask[i] & comparand[i];
        mismatch_d[mm_idx(i, MM_ONE)]  = mask[i] & ~comparand[i];
      end
    end
  end

  // An all-zero pattern after reset makes every word match.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mismatch_q <= '0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_lines = mismatch_q;

endmodule

// File: rtl/cam_compare_cells.sv
// Search datapath: compare stage feeding the associative cell array.
// Free-running, no handshake: every input is taken at every rising edge.
module cam_compare_cells #(
  parameter int WORDS = capp_pkg::WORDS,
  parameter int WIDTH = capp_pkg::WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   comparand,
  input  logic [WIDTH-1:0]   mask,
  input  logic               perform_search,
  output logic [2*WIDTH-1:0] mismatch_lines,
  input  logic [2*WIDTH-1:0] write_lines,
  input  logic               load_en,
  input  logic [6:0]         load_addr,
  input  logic [WIDTH-1:0]   load_data,
  output logic [WORDS-1:0]   match_lines,
  output logic [WIDTH-1:0]   read_lines
);

  compare #(
    .WIDTH(WIDTH)
  ) u_compare (
    .CLK           (CLK),
    .RST           (RST),
    .comparand     (comparand),
    .mask          (mask),
    .perform_search(perform_search),
    .mismatch_lines(mismatch_lines)
  );

  cells #(
    .WORDS(WORDS),
    .WIDTH(WIDTH)
  ) u_cells (
    .CLK           (CLK),
    .RST           (RST),
    .mismatch_lines(mismatch_lines),
    .write_lines   (write_lines),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .match_lines   (match_lines),
    .read_lines    (read_lines)
  );

endmodule

// File: tb/tb_cam_compare_cells.sv
// Directed bench for the search datapath: reset, masked/exact search,
// parallel write, no-match, and same-edge conflicts.
module tb_cam_compare_cells;

  localparam int WORDS = 100;
  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   comparand;
  logic [WIDTH-1:0]   mask;
  logic               perform_search;
  logic [2*WIDTH-1:0] mismatch_lines;
  logic [2*WIDTH-1:0] write_lines;
  logic               load_en;
  logic [6:0]         load_addr;
  logic [WIDTH-1:0]   load_data;
  logic [WORDS-1:0]   match_lines;
  logic [WIDTH-1:0]   read_lines;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WORDS-1:0]   exp_match;
  logic [2*WIDTH-1:0] exp_mm;

  cam_compare_cells #(
    .WORDS(WORDS),
    .WIDTH(WIDTH)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .comparand     (comparand),
    .mask          (mask),
    .perform_search(perform_search),
    .mismatch_lines(mismatch_lines),
    .write_lines   (write_lines),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .match_lines   (match_lines),
    .read_lines    (read_lines)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WORDS-1:0] one_hot(input int w);
    logic [WORDS-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] mm_model(input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[2*i]   = m[i] & c[i];
      v[2*i+1] = m[i] & ~c[i];
    end
    return v;
  endfunction

  task automatic idle_inputs();
    rst            = 1'b0;
    perform_search = 1'b0;
    write_lines    = '0;
    load_en        = 1'b0;
  endtask

  // Inputs are set away from the edge; one rising edge; sample at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic search(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    comparand      = c;
    mask           = m;
    perform_search = 1'b1;
    step();
  endtask

  task automatic load(input int addr, input logic [WIDTH-1:0] data);
    load_en   = 1'b1;
    load_addr = 7'(addr);
    load_data = data;
    step();
  endtask

  initial begin
    idle_inputs();
    comparand = '0;
    mask      = '0;
    load_addr = '0;
    load_data = '0;
    @(negedge clk);

    // Reset together with a search request: register must stay zero.
    rst            = 1'b1;
    perform_search = 1'b1;
    comparand      = 32'hFFFF_FFFF;
    mask           = 32'hFFFF_FFFF;
    step();
    check("rst_mismatch", 128'(mismatch_lines), 128'(0));
    exp_match = '1;
    check("rst_match", 128'(match_lines), 128'(exp_match));
    check("rst_read", 128'(read_lines), 128'(0));

    // Loads, including an out-of-range address that must be dropped.
    load(5, 32'd457);
    load(9, 32'd969);
    load(120, 32'hFFFF_FFFF);
    exp_match = '1;
    check("load_all_match", 128'(match_lines), 128'(exp_match));
    check("load_read_or", 128'(read_lines), 128'(32'd969));

    // Masked search: low nine bits only.
    search(32'd457, 32'h0000_01FF);
    exp_mm = mm_model(32'd457, 32'h0000_01FF);
    check("masked_mm_lines", 128'(mismatch_lines), 128'(exp_mm));
    exp_match = one_hot(5) | one_hot(9);
    check("masked_match", 128'(match_lines), 128'(exp_match));
    check("masked_read", 128'(read_lines), 128'(32'd969));

    // Exact search.
    search(32'd457, 32'hFFFF_FFFF);
    exp_match = one_hot(5);
    check("exact_match", 128'(match_lines), 128'(exp_match));
    check("exact_read", 128'(read_lines), 128'(32'd457));

    // Parallel write: set bit 31, clear bit 0 in the matching word.
    write_lines     = '0;
    write_lines[63] = 1'b1;
    write_lines[0]  = 1'b1;
    step();
    check("write_leaves_set", 128'(match_lines), 128'(0));
    check("write_leaves_read", 128'(read_lines), 128'(0));
    search(32'h8000_01C8, 32'hFFFF_FFFF);
    exp_match = one_hot(5);
    check("w5_match", 128'(match_lines), 128'(exp_match));
    check("w5_value", 128'(read_lines), 128'(32'h8000_01C8));

    // Word 9 untouched; then both-lines-asserted on it must not change it.
    search(32'd969, 32'hFFFF_FFFF);
    exp_match = one_hot(9);
    check("w9_match", 128'(match_lines), 128'(exp_match));
    write_lines = '1;
    step();
    check("both_lines_hold", 128'(read_lines), 128'(32'd969));

    // No match: a set-all write pulse must change nothing.
    search(32'd1234, 32'hFFFF_FFFF);
    check("nomatch_match", 128'(match_lines), 128'(0));
    check("nomatch_read", 128'(read_lines), 128'(0));
    for (int i = 0; i < WIDTH; i++) write_lines[2*i+1] = 1'b1;
    step();
    search(32'h0, 32'h0);
    exp_match = '1;
    check("nomatch_all", 128'(match_lines), 128'(exp_match));
    check("nomatch_contents", 128'(read_lines), 128'(32'h8000_03C9));

    // Search and write on one edge: write uses the old all-match set.
    comparand       = 32'd969;
    mask            = 32'hFFFF_FFFF;
    perform_search  = 1'b1;
    write_lines[63] = 1'b1;
    step();
    check("same_edge_new_search", 128'(match_lines), 128'(0));
    search(32'h8000_0000, 32'hFFFF_FFFF);
    exp_match = ~(one_hot(5) | one_hot(9));
    check("same_edge_set_b31", 128'(match_lines), 128'(exp_match));
    check("same_edge_read", 128'(read_lines), 128'(32'h8000_0000));

    // Load beats a same-edge write to a matching word.
    search(32'h8000_03C9, 32'hFFFF_FFFF);
    exp_match = one_hot(9);
    check("pre_load_match", 128'(match_lines), 128'(exp_match));
    write_lines = '0;
    for (int i = 0; i < WIDTH; i++) write_lines[2*i+1] = 1'b1;
    load_en   = 1'b1;
    load_addr = 7'd9;
    load_data = 32'h1234_5678;
    step();
    search(32'h1234_5678, 32'hFFFF_FFFF);
    check("load_wins_match", 128'(match_lines), 128'(exp_match));
    check("load_wins_read", 128'(read_lines), 128'(32'h1234_5678));

    // Reset again with data present.
    rst = 1'b1;
    step();
    exp_match = '1;
    check("rst2_mismatch", 128'(mismatch_lines), 128'(0));
    check("rst2_match", 128'(match_lines), 128'(exp_match));
    check("rst2_read", 128'(read_lines), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
